sd_resp_receive: RTL and testbench

- Receives the SD-card SPI response that follows a 48-bit command frame sent on MOSI by the command sender.
- Samples MISO, hunts for the response start bit within the NCR window, and shifts in either an R1 (8-bit) or an R7/R3 (40-bit) response.
- Reports completion or timeout to the main controller using the same level-held start/finish handshake as the sender.
- All logic is on the rising edge of spiClock, opposite to the sender's falling-edge launch, so MISO is sampled mid-bit.

---
 rtl/sd_resp_receive.sv | 168 ++++++++++++++++
 tb/tb_sd_resp_receive.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sd_resp_receive.sv
// SD-card SPI response receiver: hunts for the start bit on MISO, then shifts in an R1 or R7/R3 response.
// Optional R1b busy wait is compiled in when SD_RESP_BUSY_WAIT_EN is defined.
module sd_resp_receive #(
    parameter int longBits    = 40,
    parameter int shortBits   = 8,
    parameter int timeoutBits = 64
) (
    input  logic                spiClock,
    input  logic                reset,
    input  logic                start,
    input  logic                longResp,
`ifdef SD_RESP_BUSY_WAIT_EN
    input  logic                busyWait,
`endif
    input  logic                miso,
    output logic [longBits-1:0] resp,
    output logic                finish,
    output logic                error
);

    localparam int HUNT_W = $clog2(timeoutBits);
    localparam int CNT_W  = $clog2(longBits + 1);

    localparam logic [HUNT_W-1:0]   HUNT_LAST  = HUNT_W'(timeoutBits - 1);
    localparam logic [CNT_W-1:0]    LONG_CNT   = CNT_W'(longBits - 1);
    localparam logic [CNT_W-1:0]    SHORT_CNT  = CNT_W'(shortBits - 1);
    localparam logic [longBits-1:0] SHORT_MASK = {{(longBits - shortBits){1'b0}}, {shortBits{1'b1}}};

`ifdef SD_RESP_BUSY_WAIT_EN
    typedef enum logic [2:0] {IDLE, HUNT, SHIFT, DONE, BUSY} state_t;
`else
    typedef enum logic [1:0] {IDLE, HUNT, SHIFT, DONE} state_t;
`endif

    state_t              state;
    state_t              state_next;
    logic                lenSel;
    logic [HUNT_W-1:0]   huntCnt;
    logic [CNT_W-1:0]    bitCnt;
    logic [longBits-1:0] shifted;
    logic                lastBit;
    logic                huntExpired;
`ifdef SD_RESP_BUSY_WAIT_EN
    logic                busySel;
`endif

    // The shift register is masked to the selected length so R1 stays right-justified.
    assign shifted     = {resp[longBits-2:0], miso} & (lenSel ? {longBits{1'b1}} : SHORT_MASK);
    assign lastBit     = (bitCnt == CNT_W'(1));
    assign huntExpired = (huntCnt == HUNT_LAST);

    always_ff @(posedge spiClock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Dropping start always wins, even on the edge that would complete the transfer.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) state_next = HUNT;
            end
            HUNT: begin
                if (!start)                  state_next = IDLE;
                else if (!miso)              state_next = SHIFT;
                else if (huntExpired)        state_next = DONE;
            end
            SHIFT: begin
                if (!start) begin
                    state_next = IDLE;
                end else if (lastBit) begin
`ifdef SD_RESP_BUSY_WAIT_EN
                    state_next = busySel ? BUSY : DONE;
`else
                    state_next = DONE;
`endif
                end
            end
`ifdef SD_RESP_BUSY_WAIT_EN
            BUSY: begin
                if (!start)     state_next = IDLE;
                else if (miso)  state_next = DONE;
            end
`endif
            DONE: begin
                if (!start) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge spiClock) begin
        if (reset) begin
            resp    <= '0;
            finish  <= 1'b0;
            error   <= 1'b0;
            lenSel  <= 1'b0;
            huntCnt <= '0;
            bitCnt  <= '0;
`ifdef SD_RESP_BUSY_WAIT_EN
            busySel <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    finish <= 1'b0;
                    if (start) begin
                        lenSel  <= longResp;
                        resp    <= '0;
                        huntCnt <= '0;
                        error   <= 1'b0;
`ifdef SD_RESP_BUSY_WAIT_EN
                        busySel <= busyWait;
`endif
                    end
                end
                HUNT: begin
                    if (start) begin
                        if (!miso) begin
                            // The start bit itself is the response MSB, always zero.
                            resp   <= '0;
                            bitCnt <= lenSel ? LONG_CNT : SHORT_CNT;
                        end else if (huntExpired) begin
                            error  <= 1'b1;
                            finish <= 1'b1;
                            resp   <= '0;
                        end else begin
                            huntCnt <= huntCnt + HUNT_W'(1);
                        end
                    end
                end
                SHIFT: begin
                    if (start) begin
                        resp   <= shifted;
                        bitCnt <= bitCnt - CNT_W'(1);
`ifdef SD_RESP_BUSY_WAIT_EN
                        if (lastBit && !busySel) begin
`else
                        if (lastBit) begin
`endif
                            finish <= 1'b1;
                            error  <= 1'b0;
                        end
                    end
                end
`ifdef SD_RESP_BUSY_WAIT_EN
                BUSY: begin
                    if (start && miso) begin
                        finish <= 1'b1;
                        error  <= 1'b0;
                    end
                end
`endif
                DONE: begin
                    if (!start) finish <= 1'b0;
                end
                default: begin
                    finish <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_resp_receive.sv
// Self-checking bench for sd_resp_receive: directed scenarios with literal expectations plus
// randomized transactions checked every cycle against a transaction-level model.
module tb_sd_resp_receive;

    localparam int LONG_B = 40;
    localparam int SHORT_B = 8;
    localparam int TO_B = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              longResp;
    logic              busyWait;
    logic              miso;
    logic [LONG_B-1:0] resp;
    logic              finish;
    logic              error;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sd_resp_receive #(.longBits(LONG_B), .shortBits(SHORT_B), .timeoutBits(TO_B)) dut (
        .spiClock (clk),
        .reset    (reset),
        .start    (start),
        .longResp (longResp),
`ifdef SD_RESP_BUSY_WAIT_EN
        .busyWait (busyWait),
`endif
        .miso     (miso),
        .resp     (resp),
        .finish   (finish),
        .error    (error)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: counts hunt samples, collects received bits in a queue.
    bit          m_ok = 0;
    bit          m_on, m_long, m_bw, m_found, m_wait, m_end;
    int          m_samples;
    bit          bits[$];
    logic [63:0] m_resp = '0;
    bit          m_fin = 0, m_err = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_ok = 1; m_on = 0; m_resp = '0; m_fin = 0; m_err = 0;
        end else if (!start) begin
            m_on = 0; m_fin = 0;
        end else if (!m_on) begin
            m_on = 1; m_long = longResp; m_bw = busyWait; m_samples = 0;
            m_found = 0; m_wait = 0; m_end = 0; bits.delete(); m_resp = '0; m_err = 0;
        end else if (m_end) begin
            m_fin = 1;
        end else if (m_wait) begin
            if (miso) begin m_end = 1; m_fin = 1; m_err = 0; end
        end else if (!m_found) begin
            m_samples++;
            if (!miso) begin
                m_found = 1; bits.push_back(1'b0); m_resp = '0;
            end else if (m_samples == TO_B) begin
                m_end = 1; m_fin = 1; m_err = 1; m_resp = '0;
            end
        end else begin
            bits.push_back(miso);
            m_resp = '0;
            foreach (bits[i]) m_resp = m_resp * 2 + 64'(bits[i]);
            if (bits.size() == (m_long ? LONG_B : SHORT_B)) begin
                if (m_bw) m_wait = 1;
                else begin m_end = 1; m_fin = 1; m_err = 0; end
            end
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            chk("cyc_resp", 64'(resp), m_resp);
            chk("cyc_finish", 64'(finish), 64'(m_fin));
            if (m_fin) chk("cyc_error", 64'(error), 64'(m_err));
        end
    end

    task automatic run_resp(input bit lng, input int ncr, input logic [39:0] val,
                            input bit bw, input int bz, input string nm);
        int len = lng ? LONG_B : SHORT_B;
        @(negedge clk); start = 1; longResp = lng; busyWait = bw; miso = 1;
        @(negedge clk);
        repeat (ncr) begin miso = 1; @(negedge clk); end
        for (int i = len - 1; i >= 0; i--) begin
            miso = val[i];
            @(negedge clk);
            if (i > 0 || bw) chk({nm, "_early_finish"}, 64'(finish), 64'd0);
        end
        if (bw) begin
            for (int k = 0; k < bz; k++) begin
                miso = 0; @(negedge clk);
                chk({nm, "_busy_finish"}, 64'(finish), 64'd0);
            end
            miso = 1; @(negedge clk);
        end
        chk({nm, "_finish"}, 64'(finish), 64'd1);
        chk({nm, "_resp"}, 64'(resp), 64'(val));
        chk({nm, "_error"}, 64'(error), 64'd0);
        start = 0; miso = 1;
        @(negedge clk);
        chk({nm, "_finish_drop"}, 64'(finish), 64'd0);
    endtask

    task automatic rand_txn();
        bit lng = 1'($urandom_range(0, 1));
        int len = lng ? LONG_B : SHORT_B;
        int ncr = ($urandom_range(0, 7) == 0) ? 70 : $urandom_range(0, 20);
        logic [39:0] val = {8'($urandom), 32'($urandom)};
        int bz = $urandom_range(0, 6);
        int abort_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, ncr + len) : -1;
        int rst_at = ($urandom_range(0, 7) == 0) ? $urandom_range(0, ncr + len) : -1;
        bit seq[$];
        if (!lng) val = val & 40'hFF;
        val[len-1] = 1'b0;
        repeat (ncr) seq.push_back(1'b1);
        for (int i = len - 1; i >= 0; i--) seq.push_back(val[i]);
        repeat (bz) seq.push_back(1'b0);
        @(negedge clk); start = 1; longResp = lng; miso = 1;
`ifdef SD_RESP_BUSY_WAIT_EN
        busyWait = 1'($urandom_range(0, 1));
`else
        busyWait = 0;
`endif
        @(negedge clk);
        for (int c = 0; c < 200; c++) begin
            if (c == abort_at) start = 0;
            reset = (c == rst_at);
            miso = (c < seq.size()) ? seq[c] : 1'b1;
            @(negedge clk);
            reset = 0;
            if (finish || !start) break;
        end
        start = 0; miso = 1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        reset = 1; start = 0; longResp = 0; busyWait = 0; miso = 1;
        repeat (3) @(negedge clk);
        chk("reset_resp", 64'(resp), 64'd0);
        chk("reset_finish", 64'(finish), 64'd0);
        reset = 0;
        @(negedge clk);

        run_resp(0, 16, 40'h01, 0, 0, "r1_01");
        run_resp(1, 8, 40'h01000001AA, 0, 0, "r7");

        // Timeout: finish only on the 64th hunt sample.
        @(negedge clk); start = 1; longResp = 0; miso = 1;
        @(negedge clk);
        for (int s = 1; s <= TO_B; s++) begin
            miso = 1; @(negedge clk);
            chk($sformatf("timeout_s%0d", s), 64'(finish), 64'(s == TO_B));
        end
        chk("timeout_error", 64'(error), 64'd1);
        chk("timeout_resp", 64'(resp), 64'd0);
        start = 0; @(negedge clk);
        chk("timeout_drop", 64'(finish), 64'd0);

        // Reset mid-SHIFT of an R7.
        @(negedge clk); start = 1; longResp = 1; miso = 1;
        @(negedge clk);
        repeat (3) begin miso = 1; @(negedge clk); end
        for (int i = 0; i < 20; i++) begin miso = (i == 0) ? 1'b0 : 1'b1; @(negedge clk); end
        chk("midshift_partial", 64'(resp), 64'h7FFFF);
        reset = 1; start = 0; @(negedge clk);
        chk("midreset_resp", 64'(resp), 64'd0);
        chk("midreset_finish", 64'(finish), 64'd0);
        reset = 0;
        run_resp(0, 2, 40'h05, 0, 0, "r1_05");

        // Abort during SHIFT: partial value retained, finish never asserts.
        @(negedge clk); start = 1; longResp = 0; miso = 1;
        @(negedge clk);
        miso = 1; @(negedge clk);
        miso = 0; @(negedge clk);
        miso = 1; @(negedge clk);
        miso = 1; @(negedge clk);
        start = 0; miso = 1; @(negedge clk);
        chk("abort_resp", 64'(resp), 64'h3);
        repeat (3) begin
            @(negedge clk);
            chk("abort_finish", 64'(finish), 64'd0);
        end
        run_resp(0, 1, 40'h00, 0, 0, "r1_00");

`ifdef SD_RESP_BUSY_WAIT_EN
        run_resp(0, 3, 40'h00, 1, 12, "r1b");
`endif

        for (int t = 0; t < 60; t++) rand_txn();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
